// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared constants and stage record for the pipelined divider.
//             Holds the default dividend/quotient width, divisor/remainder
//             width and tag width, plus the record describing one pipeline
//             slot at those default widths.
//  Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

   localparam int c_DEF_DW = 26;   // dividend / quotient width
   localparam int c_DEF_VW = 14;   // divisor / remainder width
   localparam int c_DEF_TW = 4;    // sideband tag width

   // One pipeline slot at the default widths. pipe_divider declares the same
   // layout locally so that it can follow its own DW/VW/TW parameters.
   typedef struct packed {
      logic                valid;
      logic [c_DEF_VW-1:0] rem;
      logic [c_DEF_DW-1:0] quo;
      logic [c_DEF_DW-1:0] dividend;
      logic [c_DEF_VW-1:0] divisor;
      logic [c_DEF_TW-1:0] tag;
      logic                div0;
   } stage_rec_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_stage.sv
`default_nettype none
// ============================================================================
//  Module   : div_stage
//  Purpose  : One combinational restoring-division step. Shifts the next
//             dividend bit (MSB of i_dividend) into the partial remainder,
//             subtracts the divisor when it fits and appends the quotient bit.
//  Ports    : i_rem      - partial remainder so far (VW bits)
//             i_quo      - partial quotient so far (DW bits)
//             i_dividend - dividend bits not yet consumed, MSB next
//             i_divisor  - divisor
//             i_div0     - divisor is zero; remainder is forced to 0
//             o_rem/o_quo/o_dividend - updated values after this step
//  Revision : 1.0 - initial release
// ============================================================================
module div_stage
   import div_pkg::*;
#(
   parameter int DW = c_DEF_DW,
   parameter int VW = c_DEF_VW
)(
   input  logic [VW-1:0] i_rem,
   input  logic [DW-1:0] i_quo,
   input  logic [DW-1:0] i_dividend,
   input  logic [VW-1:0] i_divisor,
   input  logic          i_div0,
   output logic [VW-1:0] o_rem,
   output logic [DW-1:0] o_quo,
   output logic [DW-1:0] o_dividend
);

   logic [VW:0] w_trial;
   logic [VW:0] w_diff;
   logic        w_take;

   // The trial value needs VW+1 bits: the incoming remainder is < divisor,
   // so after the shift it can exceed the VW-bit range by one bit.
   assign w_trial = {i_rem, i_dividend[DW-1]};
   assign w_diff  = w_trial - {1'b0, i_divisor};
   assign w_take  = (w_trial >= {1'b0, i_divisor});

   // Either result is < divisor, so it always fits back into VW bits.
   // A zero divisor always "fits", giving all-ones quotient; the remainder
   // is pinned to 0 for that case.
   assign o_rem      = i_div0 ? '0 : VW'(w_take ? w_diff : w_trial);
   assign o_quo      = (i_quo << 1) | DW'(w_take);
   assign o_dividend = i_dividend << 1;

endmodule : div_stage
`default_nettype wire

// File: rtl/pipe_divider.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_divider
//  Purpose  : Fully pipelined unsigned divider, DW stages, one quotient bit
//             per stage (restoring, MSB first). One operation per cycle; a
//             single global advance moves or holds every stage together.
//  Ports    : clk, rst_n (synchronous, active-low)
//             in_valid/in_ready, in_dividend, in_divisor, in_tag  - request
//             out_valid/out_ready, out_quotient, out_remainder,
//             out_tag, out_div0                                  - result
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_divider
   import div_pkg::*;
#(
   parameter int DW = c_DEF_DW,
   parameter int VW = c_DEF_VW,
   parameter int TW = c_DEF_TW
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_dividend,
   input  logic [VW-1:0] in_divisor,
   input  logic [TW-1:0] in_tag,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_quotient,
   output logic [VW-1:0] out_remainder,
   output logic [TW-1:0] out_tag,
   output logic          out_div0
);

   // Same layout as div_pkg::stage_rec_t, sized by this instance's parameters.
   typedef struct packed {
      logic          valid;
      logic [VW-1:0] rem;
      logic [DW-1:0] quo;
      logic [DW-1:0] dividend;
      logic [VW-1:0] divisor;
      logic [TW-1:0] tag;
      logic          div0;
   } stage_t;

   stage_t r_pipe [DW];   // r_pipe[k] holds the slot after k+1 steps
   stage_t w_src  [DW];   // input of step k
   stage_t w_next [DW];   // output of step k
   logic   w_advance;

   // The last stage is the output register, so the whole pipe may move
   // whenever that register is empty or being drained.
   assign w_advance = !r_pipe[DW-1].valid || out_ready;
   assign in_ready  = w_advance;

   for (genvar k = 0; k < DW; k++) begin : g_stage
      logic [VW-1:0] w_rem;
      logic [DW-1:0] w_quo;
      logic [DW-1:0] w_dvd;

      if (k == 0) begin : g_head
         assign w_src[k] = '{valid:    in_valid,
                             rem:      {VW{1'b0}},
                             quo:      {DW{1'b0}},
                             dividend: in_dividend,
                             divisor:  in_divisor,
                             tag:      in_tag,
                             div0:     (in_divisor == {VW{1'b0}})};
      end else begin : g_body
         assign w_src[k] = r_pipe[k-1];
      end

      div_stage #(
         .DW (DW),
         .VW (VW)
      ) u_step (
         .i_rem      (w_src[k].rem),
         .i_quo      (w_src[k].quo),
         .i_dividend (w_src[k].dividend),
         .i_divisor  (w_src[k].divisor),
         .i_div0     (w_src[k].div0),
         .o_rem      (w_rem),
         .o_quo      (w_quo),
         .o_dividend (w_dvd)
      );

      assign w_next[k] = '{valid:    w_src[k].valid,
                           rem:      w_rem,
                           quo:      w_quo,
                           dividend: w_dvd,
                           divisor:  w_src[k].divisor,
                           tag:      w_src[k].tag,
                           div0:     w_src[k].div0};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < DW; k++) begin
            r_pipe[k] <= '0;
         end
      end else if (w_advance) begin
         for (int k = 0; k < DW; k++) begin
            r_pipe[k] <= w_next[k];
         end
      end
   end

   assign out_valid     = r_pipe[DW-1].valid;
   assign out_quotient  = r_pipe[DW-1].quo;
   assign out_remainder = r_pipe[DW-1].rem;
   assign out_tag       = r_pipe[DW-1].tag;
   assign out_div0      = r_pipe[DW-1].div0;

endmodule : pipe_divider
`default_nettype wire

// File: tb/tb_pipe_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_divider
//  Purpose  : Self-checking bench for pipe_divider at default parameters.
//             Expected results come from plain integer division.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_divider;

   localparam int c_DW = 26;
   localparam int c_VW = 14;
   localparam int c_TW = 4;

   typedef struct {
      logic [c_DW-1:0] q;
      logic [c_VW-1:0] r;
      logic [c_TW-1:0] t;
      logic            d;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [c_DW-1:0] in_dividend;
   logic [c_VW-1:0] in_divisor;
   logic [c_TW-1:0] in_tag;
   logic            out_valid;
   logic            out_ready;
   logic [c_DW-1:0] out_quotient;
   logic [c_VW-1:0] out_remainder;
   logic [c_TW-1:0] out_tag;
   logic            out_div0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_divider #(.DW(c_DW), .VW(c_VW), .TW(c_TW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_dividend   (in_dividend),
      .in_divisor    (in_divisor),
      .in_tag        (in_tag),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_quotient  (out_quotient),
      .out_remainder (out_remainder),
      .out_tag       (out_tag),
      .out_div0      (out_div0)
   );

   // Reference: arithmetic division, zero divisor gives all ones / 0 / flag.
   function automatic exp_t model(input logic [c_DW-1:0] dvd, input logic [c_VW-1:0] dvs,
                                  input logic [c_TW-1:0] tag);
      exp_t e;
      longint unsigned a;
      longint unsigned b;
      a = longint'(dvd);
      b = longint'(dvs);
      e.t = tag;
      if (b == 0) begin
         e.q = '1;
         e.r = '0;
         e.d = 1'b1;
      end else begin
         e.q = c_DW'(a / b);
         e.r = c_VW'(a % b);
         e.d = 1'b0;
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation with out_ready=1 and wait for its result.
   // lat = number of rising edges from acceptance to out_valid.
   task automatic run_one(input logic [c_DW-1:0] dvd, input logic [c_VW-1:0] dvs,
                          input logic [c_TW-1:0] tag, output int lat);
      out_ready   = 1'b1;
      in_valid    = 1'b1;
      in_dividend = dvd;
      in_divisor  = dvs;
      in_tag      = tag;
      tick();
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_dividend = '0;
      in_divisor  = '0;
      in_tag      = '0;
      tick();
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
      checks++; if (out_quotient !== '0) begin errors++; $display("FAIL reset_quo got %0h want 0", out_quotient); end
      checks++; if (out_remainder !== '0) begin errors++; $display("FAIL reset_rem got %0h want 0", out_remainder); end
      checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_tag got %0h want 0", out_tag); end
      checks++; if (out_div0 !== 1'b0) begin errors++; $display("FAIL reset_div0 got %0b want 0", out_div0); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int lat;
      run_one(26'd100, 14'd7, 4'd3, lat);
      checks++; if (lat !== 26) begin errors++; $display("FAIL basic_latency got %0d want 26", lat); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", out_valid); end
      checks++; if (out_quotient !== 26'd14) begin errors++; $display("FAIL basic_quo got %0d want 14", out_quotient); end
      checks++; if (out_remainder !== 14'd2) begin errors++; $display("FAIL basic_rem got %0d want 2", out_remainder); end
      checks++; if (out_tag !== 4'd3) begin errors++; $display("FAIL basic_tag got %0d want 3", out_tag); end
      checks++; if (out_div0 !== 1'b0) begin errors++; $display("FAIL basic_div0 got %0b want 0", out_div0); end
      tick();
   endtask

   task automatic test_back_to_back();
      int lat;
      out_ready   = 1'b1;
      in_valid    = 1'b1;
      in_dividend = 26'h3FFFFFF;
      in_divisor  = 14'd1;
      in_tag      = 4'd1;
      tick();
      in_divisor  = 14'd16383;
      in_tag      = 4'd2;
      tick();
      in_valid = 1'b0;
      lat = 2;
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
      end
      checks++; if (lat !== 26) begin errors++; $display("FAIL b2b_latency got %0d want 26", lat); end
      checks++; if (out_quotient !== 26'd67108863) begin errors++; $display("FAIL b2b_quo1 got %0d want 67108863", out_quotient); end
      checks++; if (out_remainder !== 14'd0) begin errors++; $display("FAIL b2b_rem1 got %0d want 0", out_remainder); end
      checks++; if (out_tag !== 4'd1) begin errors++; $display("FAIL b2b_tag1 got %0d want 1", out_tag); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2 got %0b want 1", out_valid); end
      checks++; if (out_quotient !== 26'd4096) begin errors++; $display("FAIL b2b_quo2 got %0d want 4096", out_quotient); end
      checks++; if (out_remainder !== 14'd4095) begin errors++; $display("FAIL b2b_rem2 got %0d want 4095", out_remainder); end
      checks++; if (out_tag !== 4'd2) begin errors++; $display("FAIL b2b_tag2 got %0d want 2", out_tag); end
      tick();
   endtask

   task automatic test_div0();
      int lat;
      run_one(26'd12345, 14'd0, 4'd7, lat);
      checks++; if (lat !== 26) begin errors++; $display("FAIL div0_latency got %0d want 26", lat); end
      checks++; if (out_quotient !== 26'h3FFFFFF) begin errors++; $display("FAIL div0_quo got %0h want 3ffffff", out_quotient); end
      checks++; if (out_remainder !== 14'd0) begin errors++; $display("FAIL div0_rem got %0d want 0", out_remainder); end
      checks++; if (out_div0 !== 1'b1) begin errors++; $display("FAIL div0_flag got %0b want 1", out_div0); end
      tick();
   endtask

   task automatic test_small();
      int lat;
      run_one(26'd5, 14'd9, 4'd12, lat);
      checks++; if (lat !== 26) begin errors++; $display("FAIL small_latency got %0d want 26", lat); end
      checks++; if (out_quotient !== 26'd0) begin errors++; $display("FAIL small_quo got %0d want 0", out_quotient); end
      checks++; if (out_remainder !== 14'd5) begin errors++; $display("FAIL small_rem got %0d want 5", out_remainder); end
      checks++; if (out_tag !== 4'd12) begin errors++; $display("FAIL small_tag got %0d want 12", out_tag); end
      tick();
   endtask

   task automatic test_stream();
      exp_t            q[$];
      exp_t            e;
      exp_t            held;
      logic            hold_pending;
      int              sent;
      int              recv;
      int              cyc;
      int              sel;
      sent = 0;
      recv = 0;
      cyc  = 0;
      hold_pending = 1'b0;
      held = '{q: '0, r: '0, t: '0, d: 1'b0};
      while (recv < 30 && cyc < 3000) begin
         if (hold_pending) begin
            checks++;
            if (out_valid !== 1'b1 || out_quotient !== held.q || out_remainder !== held.r ||
                out_tag !== held.t || out_div0 !== held.d) begin
               errors++;
               $display("FAIL stream_hold got v=%0b q=%0d r=%0d t=%0d d=%0b want v=1 q=%0d r=%0d t=%0d d=%0b",
                        out_valid, out_quotient, out_remainder, out_tag, out_div0,
                        held.q, held.r, held.t, held.d);
            end
         end
         out_ready = ($urandom_range(0, 2) != 0);
         in_valid  = (sent < 30) && ($urandom_range(0, 3) != 0);
         in_dividend = c_DW'($urandom);
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      in_divisor = '0;
         else if (sel < 3)  in_divisor = c_VW'($urandom_range(1, 15));
         else               in_divisor = c_VW'($urandom_range(1, 16383));
         in_tag = c_TW'($urandom);
         #1;
         checks++;
         if (in_ready !== (!out_valid || out_ready)) begin
            errors++;
            $display("FAIL stream_in_ready got %0b want %0b", in_ready, (!out_valid || out_ready));
         end
         if (in_valid && in_ready) begin
            q.push_back(model(in_dividend, in_divisor, in_tag));
            sent++;
         end
         hold_pending = out_valid && !out_ready;
         held = '{q: out_quotient, r: out_remainder, t: out_tag, d: out_div0};
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL stream_extra got tag=%0d want no result", out_tag);
            end else begin
               e = q.pop_front();
               if (out_quotient !== e.q || out_remainder !== e.r || out_tag !== e.t || out_div0 !== e.d) begin
                  errors++;
                  $display("FAIL stream_result got q=%0d r=%0d t=%0d d=%0b want q=%0d r=%0d t=%0d d=%0b",
                           out_quotient, out_remainder, out_tag, out_div0, e.q, e.r, e.t, e.d);
               end
            end
            recv++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (recv !== 30) begin
         errors++;
         $display("FAIL stream_count got %0d want 30", recv);
      end
      repeat (30) tick();
   endtask

   task automatic test_reset_midflight();
      int lat;
      int seen;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid    = 1'b1;
         in_dividend = c_DW'($urandom);
         in_divisor  = c_VW'($urandom_range(1, 16383));
         in_tag      = 4'd5;
         tick();
      end
      // Reset cycle with a request offered; it must be ignored.
      rst_n       = 1'b0;
      in_valid    = 1'b1;
      in_tag      = 4'd6;
      tick();
      rst_n    = 1'b1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", out_valid); end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) seen++;
         tick();
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_stale got %0d valid cycles want 0", seen); end
      run_one(26'd1000, 14'd3, 4'd9, lat);
      checks++; if (lat !== 26) begin errors++; $display("FAIL rstmid_latency got %0d want 26", lat); end
      checks++; if (out_tag !== 4'd9) begin errors++; $display("FAIL rstmid_tag got %0d want 9", out_tag); end
      checks++; if (out_quotient !== 26'd333 || out_remainder !== 14'd1) begin
         errors++; $display("FAIL rstmid_result got q=%0d r=%0d want q=333 r=1", out_quotient, out_remainder);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_div0();
      test_small();
      test_stream();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pipe_divider
`default_nettype wire

// File: doc/pipe_divider.md
PIPE_DIVIDER -- requirements
Module: pipe_divider

Interface
REQ-001 The block SHALL expose parameter DW, default 26, meaning dividend and quotient width in bits.
REQ-002 The block SHALL expose parameter VW, default 14, meaning divisor and remainder width in bits; legal range is 1 <= VW <= DW.
REQ-003 The block SHALL expose parameter TW, default 4, meaning the width of the sideband tag carried alongside each operation.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  the input operation is present.
REQ-007 in_ready  output  1  the block accepts an operation this cycle.
REQ-008 in_dividend  input  DW  unsigned dividend.
REQ-009 in_divisor  input  VW  unsigned divisor.
REQ-010 in_tag  input  TW  opaque tag, returned unchanged with the result.
REQ-011 out_valid  output  1  a result is present.
REQ-012 out_ready  input  1  the consumer takes the result this cycle.
REQ-013 out_quotient  output  DW  unsigned quotient.
REQ-014 out_remainder  output  VW  unsigned remainder.
REQ-015 out_tag  output  TW  tag of this result.
REQ-016 out_div0  output  1  the result came from a zero divisor.

Function
REQ-017 The pipeline SHALL have DW stages, each retiring one quotient bit MSB-first as a restoring step: shift the next dividend bit into a VW+1-bit partial remainder; if the partial remainder >= divisor, subtract and set the quotient bit to 1, else set the bit to 0.
REQ-018 Each stage SHALL hold a valid bit, partial remainder, partial quotient, the remaining dividend bits, divisor, tag and div0 flag.
REQ-019 A single global advance = !out_valid || out_ready SHALL move every stage forward one slot; when advance is 0, every stage SHALL hold.
REQ-020 in_ready SHALL equal advance; a transfer occurs when in_valid && in_ready.
REQ-021 An operation SHALL be accepted while in_ready is 1 and SHALL appear at the output exactly DW cycles later when no stall occurs.
REQ-022 Throughput SHALL be one operation per cycle; stalls SHALL NOT drop, duplicate or reorder operations.
REQ-023 Empty slots, from in_valid = 0 at a transfer cycle, SHALL propagate as bubbles with valid = 0.
REQ-024 A divisor of 0 SHALL produce a quotient of all ones, a remainder of 0 and out_div0 = 1.
REQ-025 When the divisor is nonzero, out_div0 SHALL be 0 and the following SHALL hold: quotient * divisor + remainder == dividend and remainder < divisor.
REQ-026 out_quotient, out_remainder, out_tag and out_div0 SHALL be stable while out_valid && !out_ready.
REQ-027 A result whose divisor exceeds the dividend SHALL give a quotient of 0 and a remainder equal to the dividend.

Reset
REQ-028 While rst_n is 0 at a clock edge, all stage valid bits and out_valid SHALL clear to 0; out_quotient, out_remainder, out_tag and out_div0 SHALL clear to 0.
REQ-029 During reset in_ready SHALL be 1, since out_valid is 0, but the block SHALL ignore in_valid in that cycle.
REQ-030 Reset asserted mid-operation SHALL discard every in-flight operation; no result from before reset SHALL appear after it.

Structure
REQ-031 Package div_pkg SHALL hold the default DW, VW and TW constants and the stage-record typedef (valid, rem, quo, dividend, divisor, tag, div0).
REQ-032 One restoring step SHALL be a combinational sub-module div_stage, instantiated DW times by a generate loop, with the registers held in pipe_divider.

Verification
REQ-033 Test: 100/7, tag 3, out_ready = 1 -> out_valid exactly 26 cycles later, quotient 14, remainder 2, tag 3, div0 0.
REQ-034 Test: 2^26-1 / 1, followed back-to-back by 2^26-1 / 16383 -> quotients 67108863 and 4096, remainders 0 and 4095, on consecutive cycles.
REQ-035 Test: 12345/0 -> quotient 0x3FFFFFF, remainder 0, div0 1.
REQ-036 Test: 30 random operations streamed while out_ready toggles pseudo-randomly -> in-order results matching the model, held stable during stalls, in_ready == !out_valid || out_ready.
REQ-037 Test: 5/9 -> quotient 0, remainder 5.
REQ-038 Test: rst_n low for 1 cycle with 10 operations in flight -> out_valid 0 thereafter until a new operation has travelled 26 cycles; no stale tags appear.
